div_seq_unit: RTL and testbench
===============================

# div_seq_unit

Parametrised multi-cycle divider for the EX stage. It decodes the ALU op itself, sign-normalises the operands, and runs a radix-2 restoring iteration over `WIDTH` cycles. It returns {remainder, quotient} for the HI/LO write-back and holds the pipeline stalled until the result is ready. It replaces a purely combinational start/signed decode with a complete handshake-driven divide engine, including annul support and divide-by-zero handling.

## Interface
Parameters:
- `WIDTH`, default 32: operand, quotient and remainder width.
- `OP_W`, default 8: ALU op code width.

Ports:
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `op`  in  `OP_W`: EX-stage ALU op. `EXE_DIV_OP` selects a signed divide; `EXE_DIVU_OP` selects an unsigned divide.
- `opdata1`  in  `WIDTH`: dividend.
- `opdata2`  in  `WIDTH`: divisor.
- `annul`  in  1: flush or exception; cancels any divide that is pending or running.
- `result`  out  2*`WIDTH`: {remainder, quotient}, i.e. HI in the upper half and LO in the lower half.
- `ready`  out  1: one-cycle pulse; `result` is valid while it is high.
- `stall_req`  out  1: request to the pipeline stall controller to freeze IF/ID/EX.
- `div_zero`  out  1: the divisor was zero. Valid together with `ready`.

## Operation
States: IDLE, ON, ZERO, END.

- **IDLE**
  - `start` = (op is DIV or DIVU) && !annul.
  - On `start`, latch the sign flag, the sign-normalised operands and their original signs.
  - If the divisor is 0 and `DIV_ZERO_FAST_EN` is defined, go to ZERO. Otherwise go to ON with the iteration counter = 0.
- **ON**
  - Each cycle: shift {partial remainder, dividend} left by 1 and trial-subtract the divisor.
  - If the trial result is non-negative, keep it and shift a 1 into the quotient. Otherwise restore and shift in 0.
  - The counter increments every cycle. When the counter reaches `WIDTH`-1, go to END.
  - If `annul` is asserted, go to IDLE immediately and discard all results.
- **ZERO**: go to END in one cycle. The result is quotient = all ones and remainder = dividend (unnormalised). `div_zero` = 1.
- **END**
  - `ready` = 1 and `result` is driven.
  - Go to IDLE the next cycle. `result` returns to 0 in IDLE.
  - `annul` in END is ignored; the write-back logic gates it.
- **Signed fix-up**, applied in END:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Absolute values are computed in `WIDTH`+1 bits, so the most-negative value is handled.
  - Most-negative / -1 yields quotient = most-negative (wrap-around) and remainder 0.
- **Unsigned**: no normalisation and no fix-up.
- **Divide by zero without the macro**: the natural iteration result is quotient = all ones and remainder = dividend. No sign fix-up is applied in the zero case. `div_zero` is still reported.
- A new op is accepted only in IDLE. The cycle after END is IDLE, so the next instruction (which is the next op once the pipeline has advanced) can start there.

## Timing
- Reset values: state = IDLE, counter = 0, `result` = 0, `ready` = 0, `stall_req` = 0, `div_zero` = 0.
- `stall_req` is combinational: (IDLE && `start`) || ON || ZERO. It is low in END so the pipeline advances on the same edge that the result is consumed.
- Latency: op presented in cycle 0 → ON for cycles 1..`WIDTH` → END with `ready` in cycle `WIDTH`+1.
- Fast zero path (`DIV_ZERO_FAST_EN` defined): `ready` in cycle 2.
- Reset asserted mid-operation: immediate return to IDLE. All outputs go to 0 asynchronously.
- `annul` together with a div op in IDLE: not started and `stall_req` = 0.

## Configuration
- `DIV_ZERO_FAST_EN`
  - Defined: a zero divisor takes the ZERO state and completes in 2 cycles.
  - Undefined: the ZERO state is not built, and a zero divisor runs the full `WIDTH` iterations.
  - The `result` and `div_zero` values are identical in both cases.

## Structure
- Shared package: the `EXE_DIV_OP`/`EXE_DIVU_OP` codes (already in the common defines), the state enum, and the result layout constants `HI_LSB` = `WIDTH` and `LO_LSB` = 0.
- One sub-module, `div_step`: a combinational single-iteration shift/trial-subtract of width `WIDTH`+1.
- The FSM, counter, normalisation and fix-up logic stay in the top module.

## Test plan
- **Unsigned basic:** DIVU 7/2 → `ready` at cycle 33, `result` = {0x00000001, 0x00000003}, `stall_req` high in cycles 0–32.
- **Signed negative dividend:** DIV -7/2 → `result` = {0xFFFFFFFF, 0xFFFFFFFD}.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → `result` = {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- **Divide by zero:** DIV 5/0 → `result` = {0x00000005, 0xFFFFFFFF}, `div_zero` = 1. `ready` at cycle 2 with the macro defined, cycle 33 without it.
- **Annul:** `annul` in cycle 10 of ON → state IDLE next cycle, no `ready`, `stall_req` = 0. A new DIVU 100/7 then gives {2, 14}.
- **Reset:** `rst_n` low in cycle 15 of ON → all outputs 0 immediately. After release, a back-to-back DIV then DIVU each complete with correct results.

Source files
------------

// File: rtl/div_seq_unit_pkg.sv
// div_seq_unit_pkg: shared op codes, FSM states and result layout for the sequential divider.
package div_seq_unit_pkg;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam int LO_LSB = 0;

    typedef enum logic [1:0] {IDLE, ON, ZERO, END} div_state_e;

    // HI half sits directly above the WIDTH-bit LO half
    function automatic int hi_lsb(input int width);
        return width;
    endfunction
endpackage

// File: rtl/div_seq_unit_step.sv
// div_step: one radix-2 restoring iteration; shifts {rem, dvd} left and trial-subtracts the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);
    logic [WIDTH:0] sh;
    logic           ge;

    assign sh    = {rem_i, dvd_i[WIDTH-1]};
    assign ge    = sh >= {1'b0, dsr_i};
    assign rem_o = ge ? WIDTH'(sh - {1'b0, dsr_i}) : sh[WIDTH-1:0];
    assign dvd_o = {dvd_i[WIDTH-2:0], ge};
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle signed/unsigned restoring divider returning {remainder, quotient}.
// Define DIV_ZERO_FAST_EN to short-cut a zero divisor through the ZERO state.
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_req,
    output logic                 div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam int HI = hi_lsb(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;

    logic             is_div, is_divu, start;
    logic [WIDTH:0]   a_ext, b_ext;
    logic [WIDTH-1:0] a_abs, b_abs, step_rem, step_quo, q_out, r_out;

    assign is_div  = op == OP_W'(EXE_DIV_OP);
    assign is_divu = op == OP_W'(EXE_DIVU_OP);
    assign start   = (is_div || is_divu) && !annul;

    // Sign-extend into WIDTH+1 bits so the most-negative operand has a representable magnitude
    assign a_ext = {is_div & opdata1[WIDTH-1], opdata1};
    assign b_ext = {is_div & opdata2[WIDTH-1], opdata2};
    assign a_abs = WIDTH'(a_ext[WIDTH] ? -a_ext : a_ext);
    assign b_abs = WIDTH'(b_ext[WIDTH] ? -b_ext : b_ext);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i(rem_q),
        .dvd_i(quo_q),
        .dsr_i(dsr_q),
        .rem_o(step_rem),
        .dvd_o(step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (start) begin
                rem_d  = '0;
                quo_d  = a_abs;
                dsr_d  = b_abs;
                qneg_d = a_ext[WIDTH] ^ b_ext[WIDTH];
                rneg_d = a_ext[WIDTH];
                zero_d = opdata2 == '0;
                cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
                state_d = (opdata2 == '0) ? ZERO : ON;
`else
                state_d = ON;
`endif
            end
            ON: if (annul) state_d = IDLE;
            else begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? END : ON;
            end
`ifdef DIV_ZERO_FAST_EN
            // Produce exactly what the full iteration would leave for a zero divisor
            ZERO: if (annul) state_d = IDLE;
            else begin
                rem_d   = quo_q;
                quo_d   = '1;
                state_d = END;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Remainder sign fix-up also restores the raw dividend in the zero-divisor case
    assign q_out = (qneg_q && !zero_q) ? -quo_q : quo_q;
    assign r_out = rneg_q ? -rem_q : rem_q;

    always_comb begin
        result = '0;
        if (state_q == END) begin
            result[HI +: WIDTH]     = r_out;
            result[LO_LSB +: WIDTH] = q_out;
        end
    end

    assign ready     = state_q == END;
    assign div_zero  = (state_q == END) && zero_q;
    assign stall_req = (state_q == IDLE && start) || state_q == ON || state_q == ZERO;
endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: directed-vector bench for div_seq_unit; expected latency follows DIV_ZERO_FAST_EN.
module tb_div_seq_unit;
    import div_seq_unit_pkg::*;

    localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = W + 1;
`endif
    localparam int LAT = W + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      op = 8'h00;
    logic [W-1:0]    a = '0, b = '0;
    logic            annul = 1'b0;
    logic [2*W-1:0]  result;
    logic            ready, stall_req, div_zero;
    int              n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    div_seq_unit #(.WIDTH(W), .OP_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .op(op),
        .opdata1(a),
        .opdata2(b),
        .annul(annul),
        .result(result),
        .ready(ready),
        .stall_req(stall_req),
        .div_zero(div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_div(input string tag, input logic [7:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [63:0] exp, input logic ez, input int lat);
        int   n;
        logic st_ok;
        @(posedge clk);
        #1 op = o; a = x; b = y;
        #1 st_ok = stall_req;
        @(posedge clk);
        #1 op = 8'h00;
        n = 1;
        while (!ready && n < 200) begin
            st_ok &= stall_req;
            @(posedge clk);
            #1 n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result, exp);
        check({tag, " div_zero"}, 64'(div_zero), 64'(ez));
        check({tag, " stall"}, 64'({st_ok, stall_req}), 64'(2'b10));
    endtask

    initial begin
        logic seen;
        #12 check("reset outputs", {result[61:0], ready, stall_req}, 64'h0);
        check("reset div_zero", 64'(div_zero), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        @(posedge clk);
        #1 op = EXE_DIV_OP; a = 32'd5; b = 32'd1; annul = 1'b1;
        #1 check("annul idle stall", 64'(stall_req), 64'h0);
        @(posedge clk);
        #1 op = 8'h00; annul = 1'b0;
        check("annul idle not started", 64'({stall_req, ready}), 64'h0);

        run_div("divu 7/2", EXE_DIVU_OP, 32'd7, 32'd2, 64'h00000001_00000003, 1'b0, LAT);
        run_div("div -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, LAT);
        run_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, LAT);
        run_div("div -8/-3", EXE_DIV_OP, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 1'b0, LAT);
        run_div("div min/-1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, LAT);
        run_div("divu max/1", EXE_DIVU_OP, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0, LAT);
        run_div("div 5/0", EXE_DIV_OP, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, ZLAT);
        run_div("div -5/0", EXE_DIV_OP, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1'b1, ZLAT);
        run_div("divu min/0", EXE_DIVU_OP, 32'h80000000, 32'd0, 64'h80000000_FFFFFFFF, 1'b1, ZLAT);

        @(posedge clk);
        #1 op = EXE_DIVU_OP; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 op = 8'h00;
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        check("annul on idle", 64'({stall_req, ready}), 64'h0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 seen |= ready | stall_req;
        end
        check("annul no ready", 64'(seen), 64'h0);
        run_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, LAT);

        @(posedge clk);
        #1 op = EXE_DIV_OP; a = 32'd100; b = 32'd3;
        @(posedge clk);
        #1 op = 8'h00;
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset mid outputs", {result[61:0], ready, stall_req}, 64'h0);
        check("reset mid div_zero", 64'(div_zero), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_div("b2b div 100/-7", EXE_DIV_OP, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 1'b0, LAT);
        run_div("b2b divu", EXE_DIVU_OP, 32'hFFFFFFFE, 32'h10, 64'h0000000E_0FFFFFFF, 1'b0, LAT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
